hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the 5-stage core. It drives PC/IF-ID write enables and the IF-ID flush, and inserts bubbles into the ID-EX register by zeroing its W/M/E control fields. It detects load-use hazards and taken-branch flushes. It also sequences a multi-cycle multiply/divide unit, stalling ID while the unit is busy.

---
 rtl/hazard_ctrl_pkg.sv | 17 +
 rtl/hazard_ctrl_md_seq.sv | 64 ++++++
 rtl/hazard_ctrl.sv | 69 ++++++
 tb/tb_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: multiply/divide sequencer state encoding and the
// ID-EX control field widths used by the bubble mux and the hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // ID-EX control fields zeroed by a bubble: writeback, memory, execute
    localparam int IDEX_W_W    = 2;
    localparam int IDEX_M_W    = 2;
    localparam int IDEX_E_W    = 4;
    localparam int IDEX_CTRL_W = IDEX_W_W + IDEX_M_W + IDEX_E_W;

endpackage

// File: rtl/hazard_ctrl_md_seq.sv
// Multiply/divide occupancy sequencer: IDLE -> RUN (LAT cycles) -> DONE (1 cycle).
// The current state is exported so hazard logic and checkers can observe it.
module hazard_ctrl_md_seq
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 16
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      accept,
    input  logic      div,
    output logic      busy,
    output logic      done,
    output md_state_e state
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CW      = $clog2(MAX_LAT);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT - 1);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT - 1);

    md_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            MD_IDLE, MD_DONE: begin
                // DONE falls back to IDLE unless a new op is accepted the same cycle
                if (accept) begin
                    state_d = MD_RUN;
                    cnt_d   = div ? DIV_LOAD : MULT_LOAD;
                end else begin
                    state_d = MD_IDLE;
                end
            end
            MD_RUN: begin
                if (cnt_q == '0) state_d = MD_DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == MD_RUN);
    assign done  = (state_q == MD_DONE);
    assign state = state_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and mult/div stalls, taken-branch flush,
// mult/div sequencing and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             id_md_start,
    input  logic             id_md_div,
    input  logic             id_hilo_read,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    md_state_e md_state;
    logic      lu, mdh, stall, md_accept;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency
    assign lu = ex_mem_read && (ex_rt != 5'd0) &&
                ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
    assign mdh   = (md_state == MD_RUN) && (id_md_start || id_hilo_read);
    assign stall = (lu || mdh) && !ex_branch_taken;

    assign md_accept = id_md_start && !stall && !ex_branch_taken && (md_state != MD_RUN);

    // While in reset the front end is frozen and ID-EX is held empty
    assign pc_write    = rst && !stall;
    assign ifid_write  = rst && !stall;
    assign ifid_flush  = !rst || ex_branch_taken;
    assign idex_bubble = !rst || stall || ex_branch_taken;

    hazard_ctrl_md_seq #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_seq (
        .clk    (clk),
        .rst    (rst),
        .accept (md_accept),
        .div    (id_md_div),
        .busy   (md_busy),
        .done   (md_done),
        .state  (md_state)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle-level reference model pushes the
// expected output vector each cycle; the vector is popped and compared mid-cycle.
module tb_hazard_ctrl;

    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 16;
    localparam int CNT_W    = 5;
    localparam int VEC_W    = 6 + CNT_W;

    logic             clk;
    logic             rst;
    logic [4:0]       id_rs, id_rt, ex_rt;
    logic             id_use_rs, id_use_rt, ex_mem_read;
    logic             id_md_start, id_md_div, id_hilo_read, ex_branch_taken;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt;

    logic [VEC_W-1:0] exp_q[$];
    int               n_checks;
    int               n_pass;

    // reference model state
    int               m_busy_left;
    bit               m_done;
    int               m_cnt;

    hazard_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .ex_mem_read     (ex_mem_read),
        .ex_rt           (ex_rt),
        .id_md_start     (id_md_start),
        .id_md_div       (id_md_div),
        .id_hilo_read    (id_hilo_read),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .md_busy         (md_busy),
        .md_done         (md_done),
        .stall_cnt       (stall_cnt)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [VEC_W-1:0] got,
                         input logic [VEC_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s t=%0t got=%b exp=%b (pc,ifid_w,flush,bubble,busy,done,cnt)",
                      tag, $time, got, exp);
    endtask

    task automatic idle_in();
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; ex_mem_read = 1'b0;
        id_md_start = 1'b0; id_md_div = 1'b0; id_hilo_read = 1'b0;
        ex_branch_taken = 1'b0;
    endtask

    // Called just after a rising edge with inputs already driven.
    task automatic cycle(input string tag);
        bit               lu, mdh, stl, acc;
        logic [VEC_W-1:0] exp_v;
        lu  = ex_mem_read && (ex_rt != 5'd0) &&
              ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        mdh = (m_busy_left > 0) && (id_md_start || id_hilo_read);
        stl = (lu || mdh) && !ex_branch_taken;
        acc = id_md_start && !stl && !ex_branch_taken && (m_busy_left == 0);
        if (!rst) begin
            m_busy_left = 0; m_done = 1'b0; m_cnt = 0;
            exp_v = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CNT_W'(0)};
        end else begin
            exp_v = {!stl, !stl, ex_branch_taken, stl || ex_branch_taken,
                     m_busy_left > 0, m_done, CNT_W'(m_cnt)};
        end
        exp_q.push_back(exp_v);
        #2;
        check(tag, {pc_write, ifid_write, ifid_flush, idex_bubble, md_busy, md_done, stall_cnt},
              exp_q.pop_front());
        @(posedge clk);
        if (rst) begin
            if (stl && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            if (acc) begin
                m_busy_left = id_md_div ? DIV_LAT : MULT_LAT;
                m_done = 1'b0;
            end else if (m_busy_left > 0) begin
                m_busy_left--;
                m_done = (m_busy_left == 0);
            end else begin
                m_done = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        n_checks = 0; n_pass = 0;
        m_busy_left = 0; m_done = 1'b0; m_cnt = 0;
        rst = 1'b0;
        idle_in();
        @(posedge clk); #1;
        cycle("reset0");
        cycle("reset1");
        rst = 1'b1;
        cycle("post_reset");

        // load-use via rs, then release
        ex_mem_read = 1'b1; ex_rt = 5'd5; id_use_rs = 1'b1; id_rs = 5'd5;
        cycle("lu_rs");
        idle_in();
        cycle("lu_rs_next");
        // load-use via rt
        ex_mem_read = 1'b1; ex_rt = 5'd9; id_use_rt = 1'b1; id_rt = 5'd9;
        cycle("lu_rt");
        // register-index mismatch and unused operand
        id_rt = 5'd8; id_use_rs = 1'b0; id_rs = 5'd9;
        cycle("lu_nomatch");
        // register zero exemption
        idle_in();
        ex_mem_read = 1'b1; id_use_rs = 1'b1; id_use_rt = 1'b1;
        cycle("lu_r0");
        idle_in();

        // multiply, then mfhi held until the DONE cycle
        id_md_start = 1'b1;
        cycle("mul_start");
        id_md_start = 1'b0; id_hilo_read = 1'b1;
        for (int i = 0; i < MULT_LAT + 1; i++) cycle("mul_hilo");
        idle_in();
        cycle("mul_after");

        // flush beats load-use and blocks an md start
        ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3;
        id_use_rs = 1'b1; id_rs = 5'd3; id_md_start = 1'b1;
        cycle("flush_vs_stall");
        idle_in();
        cycle("flush_after");

        // back-to-back divides: second one stalls through RUN, accepted in DONE
        id_md_start = 1'b1; id_md_div = 1'b1;
        cycle("div1_start");
        for (int i = 0; i < DIV_LAT + 1; i++) cycle("div2_wait");
        idle_in();
        for (int i = 0; i < DIV_LAT + 2; i++) cycle("div2_run");

        // flush during an in-flight divide does not abort it
        id_md_start = 1'b1; id_md_div = 1'b1;
        cycle("div3_start");
        idle_in();
        ex_branch_taken = 1'b1;
        cycle("div3_flush");
        idle_in();
        for (int i = 0; i < 7; i++) cycle("div3_run");
        // async reset with the counter at 7
        rst = 1'b0;
        cycle("rst_mid_div");
        cycle("rst_hold");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rst_release");
        ex_mem_read = 1'b1; ex_rt = 5'd7; id_use_rt = 1'b1; id_rt = 5'd7;
        cycle("resume_lu");
        idle_in();

        // random traffic, dense enough to saturate the stall counter
        for (int i = 0; i < 400; i++) begin
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom_range(0, 1)); id_use_rt = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            id_md_start = ($urandom_range(0, 5) == 0);
            id_md_div = 1'($urandom_range(0, 1));
            id_hilo_read = ($urandom_range(0, 3) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            cycle("random");
        end

        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain left=%0d required=0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
